timer_irq_ctrl: RTL

//  Compare/interrupt stage directly downstream of the ms timer. Consumes the free-running

---
 rtl/timer_pkg.sv | 48 ++++
 rtl/timer_cmp_unit.sv | 18 +
 rtl/timer_irq_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer compare/interrupt stage: register map,
// CTRL/STATUS bit positions, FSM state encodings and small helpers.
package timer_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [31:0] OFF_CMP    = 32'h0000_0000;
  localparam logic [31:0] OFF_CTRL   = 32'h0000_0004;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0008;
  localparam logic [31:0] OFF_PERIOD = 32'h0000_000C;
  localparam logic [31:0] OFF_TIME   = 32'h0000_0010;

  localparam int unsigned CTRL_EN_BIT       = 0;
  localparam int unsigned CTRL_PERIODIC_BIT = 1;
  localparam int unsigned CTRL_IE_BIT       = 2;
  localparam int unsigned STATUS_PEND_BIT   = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_FIRE  = 2'd2;

  // Wrap-aware "now has reached target": the modular distance lies in the lower half-range.
  function automatic logic wrap_reached(input logic [DATA_W-1:0] now,
                                        input logic [DATA_W-1:0] target);
    logic [DATA_W-1:0] diff;
    diff = now - target;
    return ~diff[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] ctrl_word(input logic en,
                                                   input logic periodic,
                                                   input logic ie);
    logic [DATA_W-1:0] word;
    word                    = {DATA_W{1'b0}};
    word[CTRL_EN_BIT]       = en;
    word[CTRL_PERIODIC_BIT] = periodic;
    word[CTRL_IE_BIT]       = ie;
    return word;
  endfunction

  function automatic logic [DATA_W-1:0] status_word(input logic pend);
    logic [DATA_W-1:0] word;
    word                  = {DATA_W{1'b0}};
    word[STATUS_PEND_BIT] = pend;
    return word;
  endfunction

endpackage

// File: rtl/timer_cmp_unit.sv
// Combinational compare/reload datapath: wrap-aware match of the tick count
// against CMP and the next periodic compare value.
module timer_cmp_unit
  import timer_pkg::*;
(
  input  logic [DATA_W-1:0] i_time,
  input  logic [DATA_W-1:0] i_cmp,
  input  logic [DATA_W-1:0] i_period,
  output logic              o_hit,
  output logic              o_period_nz,
  output logic [DATA_W-1:0] o_reload
);

  assign o_hit       = wrap_reached(i_time, i_cmp);
  assign o_reload    = i_cmp + i_period;
  assign o_period_nz = (i_period != {DATA_W{1'b0}});

endmodule

// File: rtl/timer_irq_ctrl.sv
// Compare/interrupt stage behind the ms timer: bus-mapped CMP/CTRL/STATUS/PERIOD
// registers, one-shot or auto-reload match FSM and a sticky, maskable interrupt.
module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 5,
  parameter logic [DATA_W-1:0] CMP_RST    = 32'hFFFF_FFFF,
  parameter logic [DATA_W-1:0] PERIOD_RST = 32'd1000
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic              req_in,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rvalid_out,
  input  logic [DATA_W-1:0] time_in,
  output logic              irq_out
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] A_CMP     = OFF_CMP[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] A_CTRL    = OFF_CTRL[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] A_STATUS  = OFF_STATUS[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] A_PERIOD  = OFF_PERIOD[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] A_TIME    = OFF_TIME[ADDR_W-1:0];

  logic [DATA_W-1:0] r_cmp;
  logic [DATA_W-1:0] r_period;
  logic              r_en;
  logic              r_periodic;
  logic              r_ie;
  logic              r_pend;
  logic [1:0]        r_state;
  logic              r_irq;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

  logic [ADDR_W-1:0] w_addr;
  logic              w_rd;
  logic              w_wr_cmp;
  logic              w_wr_ctrl;
  logic              w_wr_status;
  logic              w_wr_period;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              w_hit;
  logic              w_period_nz;
  logic [DATA_W-1:0] w_reload;
  logic              w_fire;
  logic              w_auto_reload;
  logic [1:0]        w_state_nxt;

  assign w_addr = addr_in & ADDR_MASK;
  assign w_rd   = req_in & ~we_in;

  timer_cmp_unit u_cmp (
    .i_time      (time_in),
    .i_cmp       (r_cmp),
    .i_period    (r_period),
    .o_hit       (w_hit),
    .o_period_nz (w_period_nz),
    .o_reload    (w_reload)
  );

  // Write strobe decode; unmapped offsets produce no strobe.
  always_comb begin
    w_wr_cmp    = 1'b0;
    w_wr_ctrl   = 1'b0;
    w_wr_status = 1'b0;
    w_wr_period = 1'b0;
    if (req_in && we_in) begin
      case (w_addr)
        A_CMP:    w_wr_cmp    = 1'b1;
        A_CTRL:   w_wr_ctrl   = 1'b1;
        A_STATUS: w_wr_status = 1'b1;
        A_PERIOD: w_wr_period = 1'b1;
        default:  w_wr_cmp    = 1'b0;
      endcase
    end else begin
      w_wr_cmp = 1'b0;
    end
  end

  // Read data mux; unmapped offsets read as zero.
  always_comb begin
    w_rdata_nxt = {DATA_W{1'b0}};
    case (w_addr)
      A_CMP:    w_rdata_nxt = r_cmp;
      A_CTRL:   w_rdata_nxt = ctrl_word(r_en, r_periodic, r_ie);
      A_STATUS: w_rdata_nxt = status_word(r_pend);
      A_PERIOD: w_rdata_nxt = r_period;
      A_TIME:   w_rdata_nxt = time_in;
      default:  w_rdata_nxt = {DATA_W{1'b0}};
    endcase
  end

  // Next-state logic; FIRE lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_en) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!r_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hit) begin
          w_state_nxt = ST_FIRE;
        end else begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_FIRE: begin
        w_fire = 1'b1;
        if (r_periodic && w_period_nz) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_auto_reload = w_fire & r_periodic & w_period_nz;

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Register file: CPU writes win over auto-reload and the one-shot EN clear.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      r_cmp      <= CMP_RST;
      r_period   <= PERIOD_RST;
      r_en       <= 1'b0;
      r_periodic <= 1'b0;
      r_ie       <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      if (w_wr_cmp) begin
        r_cmp <= wdata_in;
      end else if (w_auto_reload) begin
        r_cmp <= w_reload;
      end

      if (w_wr_period) begin
        r_period <= wdata_in;
      end

      if (w_wr_ctrl) begin
        r_en       <= wdata_in[CTRL_EN_BIT];
        r_periodic <= wdata_in[CTRL_PERIODIC_BIT];
        r_ie       <= wdata_in[CTRL_IE_BIT];
      end else if (w_fire && !w_auto_reload) begin
        r_en <= 1'b0;
      end

      if (w_fire) begin
        r_pend <= 1'b1;
      end else if (w_wr_status && wdata_in[STATUS_PEND_BIT]) begin
        r_pend <= 1'b0;
      end
    end
  end

  // Interrupt and read-response output registers.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      r_irq    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= {DATA_W{1'b0}};
    end else begin
      r_irq    <= r_pend & r_ie;
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_rdata <= w_rdata_nxt;
      end
    end
  end

  assign irq_out    = r_irq;
  assign rvalid_out = r_rvalid;
  assign rdata_out  = r_rdata;

endmodule
